// File: rtl/bla_engine.sv
// bla_engine: Bresenham line rasteriser for the 2D GPU datapath.
// Walks one latched line and streams pixels under a valid/ready handshake.
module bla_engine #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               bla_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               bla_done,
  output logic               busy
);

  localparam int DW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [COORD_W-1:0] xs, ys, xe, ye;
  logic [COORD_W-1:0] cx, cy;
  logic signed [DW-1:0] dx, dy, err;
  logic sx_neg, sy_neg;

  logic [COORD_W-1:0] adx, ady;
  logic signed [DW-1:0] adx_s, ady_s;
  logic signed [EW-1:0] e2, dx_e, dy_e;
  logic signed [DW-1:0] err_nx;
  logic step_x, step_y, at_end;

  // Absolute spans from the latched endpoints, used in SETUP.
  assign adx   = (xs < xe) ? xe - xs : xs - xe;
  assign ady   = (ys < ye) ? ye - ys : ys - ye;
  assign adx_s = $signed({2'b00, adx});
  assign ady_s = $signed({2'b00, ady});

  // Step decision uses the old err doubled; one extra bit avoids overflow.
  assign e2     = $signed({err, 1'b0});
  assign dx_e   = $signed({dx[DW-1], dx});
  assign dy_e   = $signed({dy[DW-1], dy});
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign at_end = (cx == xe) && (cy == ye);

  // Error update: sum of whichever increments apply this step.
  always_comb begin
    err_nx = err;
    if (step_x) err_nx = err_nx + dy;
    if (step_y) err_nx = err_nx + dx;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; dropping bla_en mid-line aborts without done.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bla_en) state_nx = SETUP;
      SETUP: state_nx = bla_en ? DRAW : IDLE;
      DRAW: begin
        if (!bla_en)
          state_nx = IDLE;
        else if (pix_ready && at_end)
          state_nx = DONE;
      end
      DONE:  state_nx = HOLD;
      HOLD:  if (!bla_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch endpoints, derive slope terms, walk the line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      xs     <= '0;
      ys     <= '0;
      xe     <= '0;
      ye     <= '0;
      cx     <= '0;
      cy     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bla_en) begin
            xs <= x0;
            ys <= y0;
            xe <= x1;
            ye <= y1;
          end
        end
        SETUP: begin
          dx     <= adx_s;
          dy     <= -ady_s;
          err    <= adx_s - ady_s;
          sx_neg <= !(xs < xe);
          sy_neg <= !(ys < ye);
          cx     <= xs;
          cy     <= ys;
        end
        DRAW: begin
          if (bla_en && pix_ready && !at_end) begin
            err <= err_nx;
            if (step_x) cx <= sx_neg ? cx - 1'b1 : cx + 1'b1;
            if (step_y) cy <= sy_neg ? cy - 1'b1 : cy + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_valid = (state == DRAW);
  assign pix_x     = pix_valid ? cx : '0;
  assign pix_y     = pix_valid ? cy : '0;
  assign bla_done  = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bla_engine.sv
// tb_bla_engine: self-checking bench for bla_engine.
// Integer Bresenham reference, random backpressure, abort and reset cases.
module tb_bla_engine;

  localparam int W = 10;

  logic         clk;
  logic         n_rst;
  logic         bla_en;
  logic [W-1:0] x0, y0, x1, y1;
  logic         pix_ready;
  logic         pix_valid;
  logic [W-1:0] pix_x, pix_y;
  logic         bla_done;
  logic         busy;

  int n_tests;
  int n_fail;
  int exp_x[$];
  int exp_y[$];

  bla_engine #(.COORD_W(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bla_en    (bla_en),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .bla_done  (bla_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    x0 = W'($urandom);
    y0 = W'($urandom);
    x1 = W'($urandom);
    y1 = W'($urandom);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference walk over plain integers.
  function automatic void model(input int ax0, input int ay0,
                                input int ax1, input int ay1);
    int x, y, ddx, ddy, ssx, ssy, e, e2;
    exp_x.delete();
    exp_y.delete();
    x   = ax0;
    y   = ay0;
    ddx = iabs(ax1 - ax0);
    ddy = -iabs(ay1 - ay0);
    ssx = (ax0 < ax1) ? 1 : -1;
    ssy = (ay0 < ay1) ? 1 : -1;
    e   = ddx + ddy;
    forever begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += ssx; end
      if (e2 <= ddx) begin e += ddx; y += ssy; end
    end
  endfunction

  function automatic bit pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 1;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Draw one line against exp_x/exp_y; mode 0 ready, 1 alternate, 2 random.
  task automatic run_line(input int ax0, input int ay0,
                          input int ax1, input int ay1,
                          input int mode, input int hold,
                          input string nm);
    int  idx, cyc, done_cyc;
    bit  got_done, pr;
    x0 = W'(ax0);
    y0 = W'(ay0);
    x1 = W'(ax1);
    y1 = W'(ay1);
    bla_en    = 1'b1;
    pix_ready = 1'b0;
    step();
    cyc = 1;
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s setup: valid=%b busy=%b want 0 1",
               nm, pix_valid, busy);
    end
    scramble();
    idx      = 0;
    got_done = 0;
    done_cyc = -1;
    while (!got_done && cyc < 5000) begin
      step();
      cyc++;
      scramble();
      if (bla_done === 1'b1) begin
        got_done = 1;
        done_cyc = cyc;
        n_tests++;
        if (idx != exp_x.size() || pix_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done: pixels=%0d valid=%b want %0d 0",
                   nm, idx, pix_valid, exp_x.size());
        end
      end else if (pix_valid === 1'b1) begin
        n_tests++;
        if (idx >= exp_x.size()) begin
          n_fail++;
          $display("FAIL %s extra pixel: (%0d,%0d) want none",
                   nm, pix_x, pix_y);
          pix_ready = 1'b1;
        end else if (int'(pix_x) != exp_x[idx] ||
                     int'(pix_y) != exp_y[idx]) begin
          n_fail++;
          $display("FAIL %s pixel %0d: (%0d,%0d) want (%0d,%0d)",
                   nm, idx, pix_x, pix_y, exp_x[idx], exp_y[idx]);
        end
        pr = pick_ready(mode, cyc);
        pix_ready = pr;
        if (pr) idx++;
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL %s gap at cycle %0d: valid=%b done=%b want 1",
                 nm, cyc, pix_valid, bla_done);
        got_done = 1;
      end
    end
    n_tests++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s timeout: done_cycle=%0d want pulse", nm, done_cyc);
    end else if (mode == 0 && done_cyc != exp_x.size() + 2) begin
      n_fail++;
      $display("FAIL %s done cycle: %0d want %0d",
               nm, done_cyc, exp_x.size() + 2);
    end
    pix_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      n_tests++;
      if (busy !== 1'b1 || pix_valid !== 1'b0 || bla_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold %0d: busy=%b valid=%b done=%b want 1 0 0",
                 nm, h, busy, pix_valid, bla_done);
      end
    end
    bla_en = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b valid=%b want 0 0",
               nm, busy, pix_valid);
    end
  endtask

  task automatic test_reset();
    n_rst     = 1'b0;
    bla_en    = 1'b0;
    pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    step();
    step();
    n_tests++;
    if ({pix_valid, bla_done, busy} !== 3'b000 ||
        pix_x !== '0 || pix_y !== '0) begin
      n_fail++;
      $display("FAIL reset: v=%b d=%b b=%b x=%0d y=%0d want all 0",
               pix_valid, bla_done, busy, pix_x, pix_y);
    end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_horizontal();
    exp_x = {0, 1, 2, 3};
    exp_y = {0, 0, 0, 0};
    run_line(0, 0, 3, 0, 0, 1, "horizontal");
  endtask

  task automatic test_steep();
    exp_x = {5, 5, 4, 4, 3, 3};
    exp_y = {5, 4, 3, 2, 1, 0};
    run_line(5, 5, 3, 0, 0, 1, "steep");
  endtask

  task automatic test_backpressure();
    exp_x = {0, 1, 2};
    exp_y = {0, 1, 2};
    run_line(0, 0, 2, 2, 1, 1, "backpressure");
  endtask

  task automatic test_degenerate();
    exp_x = {7};
    exp_y = {9};
    run_line(7, 9, 7, 9, 0, 6, "degenerate");
  endtask

  task automatic test_extreme();
    model(0, 0, 1023, 1023);
    run_line(0, 0, 1023, 1023, 0, 1, "extreme");
  endtask

  task automatic test_random();
    int a, b, c, d;
    for (int n = 0; n < 18; n++) begin
      if (n < 16) begin
        a = $urandom_range(0, 63);
        b = $urandom_range(0, 63);
        c = $urandom_range(0, 63);
        d = $urandom_range(0, 63);
      end else begin
        a = $urandom_range(0, 1023);
        b = $urandom_range(0, 1023);
        c = $urandom_range(0, 1023);
        d = $urandom_range(0, 1023);
      end
      model(a, b, c, d);
      run_line(a, b, c, d, (n < 16) ? 2 : 0, $urandom_range(1, 2),
               "random");
    end
  endtask

  task automatic test_abort();
    int acc;
    x0 = 0; y0 = 0; x1 = 9; y1 = 0;
    bla_en    = 1'b1;
    pix_ready = 1'b1;
    step();
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      step();
      if (pix_valid === 1'b1) acc++;
    end
    step();
    bla_en = 1'b0;
    step();
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: valid=%b busy=%b want 0 0", pix_valid, busy);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      n_tests++;
      if (bla_done !== 1'b0 || pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort quiet: done=%b valid=%b want 0 0",
                 bla_done, pix_valid);
      end
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    x0 = 2; y0 = 3; x1 = 40; y1 = 20;
    bla_en    = 1'b1;
    pix_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    n_tests++;
    if (pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: valid=%b want 1", pix_valid);
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_tests++;
    if ({pix_valid, bla_done, busy} !== 3'b000 ||
        pix_x !== '0 || pix_y !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b d=%b b=%b x=%0d y=%0d want all 0",
               pix_valid, bla_done, busy, pix_x, pix_y);
    end
    bla_en    = 1'b0;
    pix_ready = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid idle: busy=%b want 0", busy);
    end
    model(1, 2, 6, 4);
    run_line(1, 2, 6, 4, 0, 1, "after_reset");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_horizontal();
    test_steep();
    test_backpressure();
    test_degenerate();
    test_extreme();
    test_random();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
